// File: rtl/if_stage_pf_pkg.sv
// Shared constants for the prefetching instruction fetch stage.
package if_stage_pf_pkg;

  localparam int unsigned WORD_DATA_W = 32;
  localparam logic [WORD_DATA_W-1:0] ISA_NOP = 32'h0000_0013;
  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;
  localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/if_pf_fifo.sv
// Synchronous prefetch FIFO with clear, occupancy count, empty and full.
// Head entry is presented combinationally on rdata_o; no write-to-read bypass.
module if_pf_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           clear_i,
  input  logic                           push_i,
  input  logic                           pop_i,
  input  logic [WIDTH-1:0]               wdata_i,
  output logic [WIDTH-1:0]               rdata_o,
  output logic [$clog2(DEPTH):0]         count_o,
  output logic                           empty_o,
  output logic                           full_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_q];

  assign do_push = push_i & ~full_o & ~clear_i;
  assign do_pop  = pop_i & ~empty_o & ~clear_i;

  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/if_stage_pf.sv
// Instruction fetch stage with an in-order prefetch queue and req/gnt/rvalid memory port.
// Optional performance counters are built when IF_PERF_CNT_EN is defined.
module if_stage_pf
  import if_stage_pf_pkg::*;
#(
  parameter int unsigned     PC_W     = 32,
  parameter int unsigned     INSN_W   = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic [PC_W-1:0]   new_pc,
  input  logic              br_taken,
  input  logic [PC_W-1:0]   br_addr,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [INSN_W-1:0] imem_rdata,
  output logic [PC_W-1:0]   if_pc,
  output logic [INSN_W-1:0] if_insn,
  output logic              if_en
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_bubble_cnt
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned FW = PC_W + INSN_W;
  localparam logic [INSN_W-1:0] NOP = INSN_W'(ISA_NOP);

  logic [PC_W-1:0]   fpc_q, fpc_d, rpc_q, rpc_d, if_pc_q, if_pc_d;
  logic [INSN_W-1:0] if_insn_q, if_insn_d;
  logic              if_en_q, if_en_d;
  logic [CW-1:0]     out_q, out_d, drop_q, drop_d;

  logic              fifo_clear, fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [FW-1:0]     fifo_rdata;
  logic [CW-1:0]     fifo_count;

  logic              redirect, credit, grant;
  logic [PC_W-1:0]   target;

  assign redirect  = flush | br_taken;
  assign target    = flush ? new_pc : br_addr;
  // Queue slots are reserved at request time, so responses can never overflow it.
  assign credit    = ({1'b0, fifo_count} + {1'b0, out_q}) < (CW+1)'(DEPTH);
  assign imem_req  = ~reset & ~redirect & credit;
  assign imem_addr = fpc_q;
  assign grant     = imem_req & imem_gnt;

  if_pf_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FW)
  ) u_fifo (
    .clk_i   (clk),
    .reset_i (reset),
    .clear_i (fifo_clear),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i ({rpc_q, imem_rdata}),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  always_comb begin
    fpc_d      = fpc_q;
    rpc_d      = rpc_q;
    out_d      = out_q + CW'(grant) - CW'(imem_rvalid);
    drop_d     = drop_q;
    if_pc_d    = if_pc_q;
    if_insn_d  = if_insn_q;
    if_en_d    = if_en_q;
    fifo_clear = 1'b0;
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;
    if (redirect) begin
      // Everything still in flight, except a response landing now, belongs to the old stream.
      fpc_d      = target;
      rpc_d      = target;
      fifo_clear = 1'b1;
      drop_d     = out_q - CW'(imem_rvalid);
      if_pc_d    = target;
      if_insn_d  = NOP;
      if_en_d    = DISABLE;
    end else begin
      if (grant) fpc_d = fpc_q + PC_W'(PC_INC);
      if (imem_rvalid) begin
        if (drop_q != '0) begin
          drop_d = drop_q - CW'(1);
        end else begin
          fifo_push = ~fifo_full;
          rpc_d     = rpc_q + PC_W'(PC_INC);
        end
      end
      if (!stall) begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          if_pc_d   = fifo_rdata[FW-1:INSN_W];
          if_insn_d = fifo_rdata[INSN_W-1:0];
          if_en_d   = ENABLE;
        end else begin
          if_insn_d = NOP;
          if_en_d   = DISABLE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fpc_q     <= RESET_PC;
      rpc_q     <= RESET_PC;
      out_q     <= '0;
      drop_q    <= '0;
      if_pc_q   <= '0;
      if_insn_q <= NOP;
      if_en_q   <= DISABLE;
    end else begin
      fpc_q     <= fpc_d;
      rpc_q     <= rpc_d;
      out_q     <= out_d;
      drop_q    <= drop_d;
      if_pc_q   <= if_pc_d;
      if_insn_q <= if_insn_d;
      if_en_q   <= if_en_d;
    end
  end

  assign if_pc   = if_pc_q;
  assign if_insn = if_insn_q;
  assign if_en   = if_en_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, bubble_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (fifo_push) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (~stall & fifo_empty & ~redirect) bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign perf_fetch_cnt  = fetch_cnt_q;
  assign perf_bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage_pf.sv
// Self-checking bench for if_stage_pf: sequential-PC stream model plus a randomised memory responder.
module tb_if_stage_pf;
  import if_stage_pf_pkg::*;

  logic        clk = 1'b0;
  logic        reset, stall, flush, br_taken;
  logic [31:0] new_pc, br_addr;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] if_pc, if_insn;
  logic        if_en;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_bubble_cnt;
`endif

  if_stage_pf #(.PC_W(32), .INSN_W(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .new_pc(new_pc),
    .br_taken(br_taken), .br_addr(br_addr), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_pc(if_pc), .if_insn(if_insn), .if_en(if_en)
`ifdef IF_PERF_CNT_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_bubble_cnt(perf_bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: data at address A is A+128; responses in order, >=1 cycle after grant.
  typedef struct { logic [31:0] addr; int due; } resp_t;
  resp_t pend[$];
  bit    gnt_en    = 1'b1;
  bit    rand_mode = 1'b0;
  int    fixed_dly = 0;
  logic [31:0] exp_fpc = 32'h0;

  // Stream model: delivered instructions carry consecutive PCs from the last redirect target.
  logic [31:0] exp_pc = 32'h0, last_pc = 32'h0, last_insn = 32'h0;
  logic        last_en = 1'b0;
  int          emitted = 0, bubbles = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    forever begin
      @(negedge clk);
      imem_rvalid = 1'b0;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = pend[0].addr + 32'd128;
        void'(pend.pop_front());
      end
      imem_gnt = gnt_en && (!rand_mode || $urandom_range(0, 3) != 0);
      if (reset) begin
        chk("req_in_reset", 32'(imem_req), 32'd0);
        exp_fpc = 32'h0;
      end else if (flush || br_taken) begin
        chk("req_in_redirect", 32'(imem_req), 32'd0);
        exp_fpc = flush ? new_pc : br_addr;
      end else if (imem_req && imem_gnt) begin
        resp_t r;
        chk("req_addr", imem_addr, exp_fpc);
        exp_fpc = exp_fpc + 32'd4;
        r.addr = imem_addr;
        r.due  = cyc + 1 + (rand_mode ? int'($urandom_range(0, 3)) : fixed_dly);
        pend.push_back(r);
      end
    end
  end

  task automatic check_stream();
    logic [31:0] t;
    if (reset) begin
      chk("rst_en", 32'(if_en), 32'd0);
      chk("rst_pc", if_pc, 32'h0);
      chk("rst_insn", if_insn, ISA_NOP);
      exp_pc = 32'h0;
    end else if (flush || br_taken) begin
      t = flush ? new_pc : br_addr;
      chk("redir_pc", if_pc, t);
      chk("redir_en", 32'(if_en), 32'd0);
      chk("redir_insn", if_insn, ISA_NOP);
      exp_pc = t;
    end else if (stall) begin
      chk("stall_pc", if_pc, last_pc);
      chk("stall_insn", if_insn, last_insn);
      chk("stall_en", 32'(if_en), 32'(last_en));
    end else if (if_en) begin
      chk("stream_pc", if_pc, exp_pc);
      chk("stream_insn", if_insn, exp_pc + 32'd128);
      exp_pc = exp_pc + 32'd4;
      emitted++;
    end else begin
      chk("bubble_insn", if_insn, ISA_NOP);
      chk("bubble_pc", if_pc, last_pc);
      bubbles++;
    end
    last_pc = if_pc; last_insn = if_insn; last_en = if_en;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_stream();
  endtask

  task automatic wait_en(input int budget, input string tag);
    bit found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      tick();
      if (if_en) found = 1'b1;
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  task automatic drain(input string tag);
    gnt_en = 1'b0;
    for (int i = 0; i < 50 && pend.size() > 0; i++) tick();
    chk(tag, 32'(pend.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, b0;
    reset = 1'b1; stall = 1'b0; flush = 1'b0; br_taken = 1'b0;
    new_pc = '0; br_addr = '0;
    repeat (3) tick();

    // Reset release latency with gnt=1 and 1-cycle responses.
    reset = 1'b0;
    tick(); chk("lat_e1_en", 32'(if_en), 32'd0);
    tick(); chk("lat_e2_en", 32'(if_en), 32'd0);
    tick(); chk("lat_e3_en", 32'(if_en), 32'd1);
    chk("lat_e3_pc", if_pc, 32'h0);
    chk("lat_e3_insn", if_insn, 32'd128);
    tick(); chk("lat_e4_pc", if_pc, 32'h4);
    repeat (5) tick();

    // Stall until credits run out, then resume without gap or duplicate.
    stall = 1'b1;
    repeat (6) tick();
    chk("stall_req_low", 32'(imem_req), 32'd0);
    stall = 1'b0;
    repeat (8) tick();

    // Flush with two responses in flight.
    fixed_dly = 1;
    repeat (6) tick();
    flush = 1'b1; new_pc = 32'h154;
    tick();
    chk("flush_pc", if_pc, 32'h154);
    flush = 1'b0;
    wait_en(20, "flush_wait");
    chk("flush_first_pc", if_pc, 32'h154);
    chk("flush_first_insn", if_insn, 32'h154 + 32'd128);
    repeat (4) tick();

    // Branch taken together with stall: redirect wins.
    br_taken = 1'b1; br_addr = 32'h100; stall = 1'b1;
    tick();
    chk("br_stall_pc", if_pc, 32'h100);
    chk("br_stall_en", 32'(if_en), 32'd0);
    br_taken = 1'b0; stall = 1'b0;
    wait_en(20, "br_wait");
    chk("br_first_pc", if_pc, 32'h100);
    repeat (4) tick();

    // Flush has priority over br_taken.
    flush = 1'b1; new_pc = 32'h200; br_taken = 1'b1; br_addr = 32'h300;
    tick();
    chk("prio_pc", if_pc, 32'h200);
    flush = 1'b0; br_taken = 1'b0;
    wait_en(20, "prio_wait");
    chk("prio_first_pc", if_pc, 32'h200);

    // Random gnt/rvalid delays, random stalls and occasional redirects.
    rand_mode = 1'b1;
    e0 = emitted;
    for (int i = 0; i < 400; i++) begin
      stall = ($urandom_range(0, 4) == 0);
      flush = 1'b0; br_taken = 1'b0;
      if ($urandom_range(0, 39) == 0) begin
        if ($urandom_range(0, 1) == 0) begin
          flush = 1'b1; new_pc = 32'($urandom_range(0, 16'hFFFF)) << 2;
        end else begin
          br_taken = 1'b1; br_addr = 32'($urandom_range(0, 16'hFFFF)) << 2;
        end
      end
      tick();
    end
    stall = 1'b0; flush = 1'b0; br_taken = 1'b0;
    chk("random_progress", 32'(emitted - e0 >= 60), 32'd1);

    // Reset mid-operation after draining in-flight responses.
    drain("drain_before_reset");
    reset = 1'b1;
    tick(); tick();
`ifdef IF_PERF_CNT_EN
    chk("perf_fetch_rst", perf_fetch_cnt, 32'd0);
    chk("perf_bubble_rst", perf_bubble_cnt, 32'd0);
`endif
    reset = 1'b0; gnt_en = 1'b1;
    e0 = emitted; b0 = bubbles;
    wait_en(10, "rerst_wait");
    chk("rerst_first_pc", if_pc, 32'h0);
    repeat (20) tick();
    drain("drain_end");
    repeat (8) tick();
`ifdef IF_PERF_CNT_EN
    chk("perf_fetch", perf_fetch_cnt, 32'(emitted - e0));
    chk("perf_bubble", perf_bubble_cnt, 32'(bubbles - b0));
`endif
    chk("end_idle_en", 32'(if_en), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
